magnitude_dma_accel: RTL and testbench
======================================

// Module: magnitude_dma_accel
// PURPOSE
// - Next-gen magnitude accelerator: a single block holding the Avalon-MM control slave and the Avalon-MM master datapath.
// - The CPU programs the source address, destination address, sample count and mode, then starts the block.
// - The block streams packed complex words {re,im} from memory and writes one magnitude word per sample.
// - Adds over the previous generation: programmable length, two magnitude modes, abort, a progress counter and an interrupt.
// PARAMETERS
// avs_avalonslave_data_width     32  slave data width
// avs_avalonslave_address_width  4   slave word-address width (registers 0..5 used)
// avm_avalonmaster_data_width    32  master data width; SW = width/2 = sample component width
// avm_avalonmaster_address_width 32  master byte-address width
// len_width                      16  width of LENGTH and COUNT
// PORTS
// csi_clock_clk             in   1    clock
// csi_clock_reset_n         in   1    async active-low reset
// avs_avalonslave_address   in   AW   register word address
// avs_avalonslave_read      in   1    register read strobe
// avs_avalonslave_write     in   1    register write strobe
// avs_avalonslave_writedata in   DW   register write data
// avs_avalonslave_readdata  out  DW   register read data, registered, 1-cycle latency
// avm_avalonmaster_address  out  MAW  byte address
// avm_avalonmaster_read     out  1    read request
// avm_avalonmaster_write    out  1    write request
// avm_avalonmaster_writedata out MDW  magnitude result
// avm_avalonmaster_waitrequest in 1   stall; a request completes on the cycle it is low
// avm_avalonmaster_readdata in   MDW  read data, valid on the completing read cycle
// ins_irq_irq               out  1    level interrupt = STATUS.DONE & CTRL.IRQ_EN
// BEHAVIOUR
// - Reset: all regs 0, FSM IDLE, all outputs 0.
// - Regs:
//   - 0 CTRL: b0 START (W1, self-clearing, reads 0), b1 MODE, b2 IRQ_EN, b3 ABORT (W1, self-clearing).
//   - 1 STATUS (RO except W1C): b0 BUSY, b1 DONE (sticky, W1C), b2 ABORTED (sticky, W1C).
//   - 2 SRC, 3 DST, 4 LENGTH (samples).
//   - 5 COUNT (RO): samples written in the current or last run. Unused addresses read 0.
// - SRC/DST/LENGTH/MODE writes while BUSY are ignored. IRQ_EN is always writable.
// - START while BUSY is ignored.
// - START in IDLE:
//   - clears DONE, ABORTED and COUNT, and sets BUSY.
//   - LENGTH=0: DONE is set the next cycle with no bus traffic.
// - FSM: IDLE -> RD -> CALC -> WR -> (COUNT==LENGTH ? FIN : RD); FIN -> IDLE.
//   - FIN sets DONE and clears BUSY.
// - RD:
//   - drives read=1 and address=SRC+i*(MDW/8).
//   - holds address and read stable while waitrequest=1.
//   - latches readdata on the cycle waitrequest=0.
// - CALC takes 1 cycle.
//   - re=rd[MDW-1:SW], im=rd[SW-1:0], both signed.
//   - MODE0: re*re+im*im.
//   - MODE1: |re|+|im|, computed in SW+1 bits; |-2^(SW-1)| is exact.
//   - Saturate: if the result exceeds MDW bits, output all-ones. Otherwise zero-extend.
// - WR:
//   - drives write=1, address=DST+i*(MDW/8) and the result.
//   - holds them stable while waitrequest=1.
//   - COUNT increments on completion.
// - Never drive read and write together.
// - Minimum rate is 3 cycles per sample.
// - Address arithmetic wraps modulo 2^MAW.
// - ABORT while BUSY:
//   - an in-flight request completes first; no new request is issued after it.
//   - then go IDLE, set ABORTED and clear BUSY. DONE stays 0 and COUNT is frozen.
// - ABORT and START in the same write: ABORT wins, so no run starts.
// - A W1C of DONE in the same cycle FIN sets it: the set wins.
// - Async reset mid-run: all requests deasserted immediately, all state cleared.
// TESTING
// 1. SRC=0x100, DST=0x200, LEN=2, MODE0; mem {3,4},{-5,12} -> writes 25 @0x200 and 169 @0x204; DONE=1, COUNT=2.
// 2. MODE1, sample {0x8000,0x8000} -> result 0x0001_0000. MODE0 same sample -> 0x8000_0000, no saturation.
// 3. waitrequest held high 5 cycles on each read and write -> address and data stable throughout; results unchanged.
// 4. LEN=0, START, IRQ_EN=1 -> no bus access; DONE and irq high next cycle; W1C DONE drops irq.
// 5. LEN=100; ABORT after 10 writes -> in-flight request completes, ABORTED=1, DONE=0, COUNT 10 or 11; START while BUSY ignored.
// 6. Reset asserted mid-WR -> write drops immediately; all registers read 0 after release.

Source files
------------

// File: rtl/magnitude_dma_accel.sv
// Magnitude accelerator: Avalon-MM register slave plus a master that reads packed
// complex samples {re,im} and writes one saturated magnitude word per sample.
module magnitude_dma_accel #(
   parameter int avs_avalonslave_data_width     = 32,
   parameter int avs_avalonslave_address_width  = 4,
   parameter int avm_avalonmaster_data_width    = 32,
   parameter int avm_avalonmaster_address_width = 32,
   parameter int len_width                      = 16
) (
   input  logic                                      csi_clock_clk,
   input  logic                                      csi_clock_reset_n,
   input  logic [avs_avalonslave_address_width-1:0]  avs_avalonslave_address,
   input  logic                                      avs_avalonslave_read,
   input  logic                                      avs_avalonslave_write,
   input  logic [avs_avalonslave_data_width-1:0]     avs_avalonslave_writedata,
   output logic [avs_avalonslave_data_width-1:0]     avs_avalonslave_readdata,
   output logic [avm_avalonmaster_address_width-1:0] avm_avalonmaster_address,
   output logic                                      avm_avalonmaster_read,
   output logic                                      avm_avalonmaster_write,
   output logic [avm_avalonmaster_data_width-1:0]    avm_avalonmaster_writedata,
   input  logic                                      avm_avalonmaster_waitrequest,
   input  logic [avm_avalonmaster_data_width-1:0]    avm_avalonmaster_readdata,
   output logic                                      ins_irq_irq
);

   localparam int DW  = avs_avalonslave_data_width;
   localparam int AW  = avs_avalonslave_address_width;
   localparam int MDW = avm_avalonmaster_data_width;
   localparam int MAW = avm_avalonmaster_address_width;
   localparam int LW  = len_width;
   localparam int SW  = MDW / 2;

   localparam logic [MAW-1:0] STRIDE      = MAW'(MDW / 8);
   localparam logic [AW-1:0]  ADDR_CTRL   = AW'(0);
   localparam logic [AW-1:0]  ADDR_STATUS = AW'(1);
   localparam logic [AW-1:0]  ADDR_SRC    = AW'(2);
   localparam logic [AW-1:0]  ADDR_DST    = AW'(3);
   localparam logic [AW-1:0]  ADDR_LEN    = AW'(4);
   localparam logic [AW-1:0]  ADDR_COUNT  = AW'(5);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CALC = 3'd2,
      ST_WR   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   state_t             state_r;
   logic               mode_r;
   logic               irq_en_r;
   logic               busy_r;
   logic               done_r;
   logic               aborted_r;
   logic               abort_pend_r;
   logic [MAW-1:0]     src_r;
   logic [MAW-1:0]     dst_r;
   logic [LW-1:0]      len_r;
   logic [LW-1:0]      count_r;
   logic [MDW-1:0]     rd_data_r;
   logic [MDW-1:0]     res_r;
   logic [MAW-1:0]     addr_r;
   logic               read_r;
   logic               write_r;
   logic [DW-1:0]      readdata_r;

   logic               ctrl_wr_s;
   logic               start_s;
   logic               abort_s;
   logic [LW-1:0]      cnt_next_s;
   logic [MAW-1:0]     src_addr_s;
   logic [MAW-1:0]     dst_addr_s;

   logic signed [SW-1:0]   re_s;
   logic signed [SW-1:0]   im_s;
   logic signed [2*SW-1:0] re_ext_s;
   logic signed [2*SW-1:0] im_ext_s;
   logic signed [2*SW-1:0] re_sq_s;
   logic signed [2*SW-1:0] im_sq_s;
   logic signed [SW:0]     re_wide_s;
   logic signed [SW:0]     im_wide_s;
   logic [SW:0]            re_abs_s;
   logic [SW:0]            im_abs_s;
   logic [MDW:0]           sum_sq_s;
   logic [MDW:0]           abs_sum_s;
   logic [MDW:0]           mag_wide_s;
   logic [MDW-1:0]         mag_s;

   // Control-write decode and per-sample address generation
   always_comb begin
      ctrl_wr_s  = avs_avalonslave_write && (avs_avalonslave_address == ADDR_CTRL);
      start_s    = ctrl_wr_s && avs_avalonslave_writedata[0] && !avs_avalonslave_writedata[3];
      abort_s    = abort_pend_r || (ctrl_wr_s && avs_avalonslave_writedata[3]);
      cnt_next_s = count_r + LW'(1'b1);
      src_addr_s = src_r + MAW'(cnt_next_s) * STRIDE;
      dst_addr_s = dst_r + MAW'(count_r) * STRIDE;
   end

   // Magnitude of the latched sample; one extra bit catches overflow for saturation
   always_comb begin
      re_s      = rd_data_r[MDW-1:SW];
      im_s      = rd_data_r[SW-1:0];
      re_ext_s  = (2*SW)'(re_s);
      im_ext_s  = (2*SW)'(im_s);
      re_sq_s   = re_ext_s * re_ext_s;
      im_sq_s   = im_ext_s * im_ext_s;
      sum_sq_s  = (MDW+1)'($unsigned(re_sq_s)) + (MDW+1)'($unsigned(im_sq_s));
      re_wide_s = (SW+1)'(re_s);
      im_wide_s = (SW+1)'(im_s);
      if (re_wide_s[SW]) begin
         re_abs_s = $unsigned(-re_wide_s);
      end else begin
         re_abs_s = $unsigned(re_wide_s);
      end
      if (im_wide_s[SW]) begin
         im_abs_s = $unsigned(-im_wide_s);
      end else begin
         im_abs_s = $unsigned(im_wide_s);
      end
      abs_sum_s = (MDW+1)'(re_abs_s) + (MDW+1)'(im_abs_s);
      if (mode_r) begin
         mag_wide_s = abs_sum_s;
      end else begin
         mag_wide_s = sum_sq_s;
      end
      if (mag_wide_s[MDW]) begin
         mag_s = {MDW{1'b1}};
      end else begin
         mag_s = mag_wide_s[MDW-1:0];
      end
   end

   // Register file and run sequencer; later assignments take priority (e.g. FIN over W1C)
   always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
      if (!csi_clock_reset_n) begin
         state_r      <= ST_IDLE;
         mode_r       <= 1'b0;
         irq_en_r     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         aborted_r    <= 1'b0;
         abort_pend_r <= 1'b0;
         src_r        <= {MAW{1'b0}};
         dst_r        <= {MAW{1'b0}};
         len_r        <= {LW{1'b0}};
         count_r      <= {LW{1'b0}};
         rd_data_r    <= {MDW{1'b0}};
         res_r        <= {MDW{1'b0}};
         addr_r       <= {MAW{1'b0}};
         read_r       <= 1'b0;
         write_r      <= 1'b0;
      end else begin
         if (avs_avalonslave_write) begin
            case (avs_avalonslave_address)
               ADDR_CTRL: begin
                  irq_en_r <= avs_avalonslave_writedata[2];
                  if (!busy_r) mode_r <= avs_avalonslave_writedata[1];
               end
               ADDR_STATUS: begin
                  if (avs_avalonslave_writedata[1]) done_r <= 1'b0;
                  if (avs_avalonslave_writedata[2]) aborted_r <= 1'b0;
               end
               ADDR_SRC: if (!busy_r) src_r <= MAW'(avs_avalonslave_writedata);
               ADDR_DST: if (!busy_r) dst_r <= MAW'(avs_avalonslave_writedata);
               ADDR_LEN: if (!busy_r) len_r <= LW'(avs_avalonslave_writedata);
               default: ;
            endcase
         end
         if (ctrl_wr_s && avs_avalonslave_writedata[3] && busy_r) abort_pend_r <= 1'b1;

         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  done_r    <= 1'b0;
                  aborted_r <= 1'b0;
                  count_r   <= {LW{1'b0}};
                  busy_r    <= 1'b1;
                  if (len_r == {LW{1'b0}}) begin
                     state_r <= ST_FIN;
                  end else begin
                     read_r  <= 1'b1;
                     addr_r  <= src_r;
                     state_r <= ST_RD;
                  end
               end
            end
            ST_RD: begin
               if (!avm_avalonmaster_waitrequest) begin
                  read_r    <= 1'b0;
                  rd_data_r <= avm_avalonmaster_readdata;
                  if (abort_s) begin
                     state_r      <= ST_IDLE;
                     busy_r       <= 1'b0;
                     aborted_r    <= 1'b1;
                     abort_pend_r <= 1'b0;
                  end else begin
                     state_r <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               res_r <= mag_s;
               if (abort_s) begin
                  state_r      <= ST_IDLE;
                  busy_r       <= 1'b0;
                  aborted_r    <= 1'b1;
                  abort_pend_r <= 1'b0;
               end else begin
                  write_r <= 1'b1;
                  addr_r  <= dst_addr_s;
                  state_r <= ST_WR;
               end
            end
            ST_WR: begin
               if (!avm_avalonmaster_waitrequest) begin
                  write_r <= 1'b0;
                  count_r <= cnt_next_s;
                  if (abort_s) begin
                     state_r      <= ST_IDLE;
                     busy_r       <= 1'b0;
                     aborted_r    <= 1'b1;
                     abort_pend_r <= 1'b0;
                  end else if (cnt_next_s == len_r) begin
                     state_r <= ST_FIN;
                  end else begin
                     read_r  <= 1'b1;
                     addr_r  <= src_addr_s;
                     state_r <= ST_RD;
                  end
               end
            end
            ST_FIN: begin
               done_r       <= 1'b1;
               busy_r       <= 1'b0;
               abort_pend_r <= 1'b0;
               state_r      <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               read_r  <= 1'b0;
               write_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Registered slave read mux, one cycle of latency
   always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
      if (!csi_clock_reset_n) begin
         readdata_r <= {DW{1'b0}};
      end else if (avs_avalonslave_read) begin
         case (avs_avalonslave_address)
            ADDR_CTRL:   readdata_r <= DW'({irq_en_r, mode_r, 1'b0});
            ADDR_STATUS: readdata_r <= DW'({aborted_r, done_r, busy_r});
            ADDR_SRC:    readdata_r <= DW'(src_r);
            ADDR_DST:    readdata_r <= DW'(dst_r);
            ADDR_LEN:    readdata_r <= DW'(len_r);
            ADDR_COUNT:  readdata_r <= DW'(count_r);
            default:     readdata_r <= {DW{1'b0}};
         endcase
      end else begin
         readdata_r <= {DW{1'b0}};
      end
   end

   assign avs_avalonslave_readdata   = readdata_r;
   assign avm_avalonmaster_address   = addr_r;
   assign avm_avalonmaster_read      = read_r;
   assign avm_avalonmaster_write     = write_r;
   assign avm_avalonmaster_writedata = res_r;
   assign ins_irq_irq                = done_r & irq_en_r;

endmodule

// File: tb/tb_magnitude_dma_accel.sv
// Randomized bench for magnitude_dma_accel: memory/stall responder on the master
// port, expected-transfer queues built from a plain-arithmetic magnitude model.
module tb_magnitude_dma_accel;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  s_addr = 4'h0;
   logic        s_read = 1'b0;
   logic        s_write = 1'b0;
   logic [31:0] s_wdata = 32'h0;
   logic [31:0] s_rdata;
   logic [31:0] m_addr;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_wdata;
   logic        m_wait = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   logic        irq;

   magnitude_dma_accel dut (
      .csi_clock_clk               (clk),
      .csi_clock_reset_n           (rst_n),
      .avs_avalonslave_address     (s_addr),
      .avs_avalonslave_read        (s_read),
      .avs_avalonslave_write       (s_write),
      .avs_avalonslave_writedata   (s_wdata),
      .avs_avalonslave_readdata    (s_rdata),
      .avm_avalonmaster_address    (m_addr),
      .avm_avalonmaster_read       (m_read),
      .avm_avalonmaster_write      (m_write),
      .avm_avalonmaster_writedata  (m_wdata),
      .avm_avalonmaster_waitrequest(m_wait),
      .avm_avalonmaster_readdata   (m_rdata),
      .ins_irq_irq                 (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int wr_done = 0;

   logic [31:0] mem  [logic [31:0]];
   logic [31:0] wmem [logic [31:0]];
   logic [31:0] exp_rd [$];
   logic [63:0] exp_wr [$];

   bit          fixed_stall = 1'b0;
   int          fixed_len = 0;
   int          stall_left = 0;
   bit          pend = 1'b0;
   logic [31:0] p_addr;
   logic [31:0] p_wdata;
   logic        p_read;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: event not expected / not seen", name);
   endtask

   function automatic logic [31:0] rmem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] rwmem(input logic [31:0] a);
      if (wmem.exists(a)) return wmem[a];
      return 32'hxxxx_xxxx;
   endfunction

   // Reference magnitude computed with plain integer arithmetic
   function automatic logic [31:0] mag_model(input logic [31:0] w, input bit mode);
      int re, im;
      longint r;
      re = $signed(w[31:16]);
      im = $signed(w[15:0]);
      if (mode) r = longint'(re < 0 ? -re : re) + longint'(im < 0 ? -im : im);
      else      r = longint'(re) * re + longint'(im) * im;
      if (r > 64'sh0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
      return r[31:0];
   endfunction

   // Master-port responder and per-cycle compare against the expected queues
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
         m_wait = 1'b0;
      end else if (m_read || m_write) begin
         check("rd_wr_excl", {31'b0, m_read & m_write}, 32'h0);
         if (pend) begin
            check("hold_addr", m_addr, p_addr);
            check("hold_kind", {31'b0, m_read}, {31'b0, p_read});
            if (m_write) check("hold_data", m_wdata, p_wdata);
         end else begin
            stall_left = fixed_stall ? fixed_len : $urandom_range(0, 2);
            p_addr  = m_addr;
            p_read  = m_read;
            p_wdata = m_wdata;
         end
         if (stall_left > 0) begin
            stall_left--;
            pend    = 1'b1;
            m_wait  = 1'b1;
            m_rdata = $urandom;
         end else begin
            pend   = 1'b0;
            m_wait = 1'b0;
            if (m_read) begin
               m_rdata = rmem(m_addr);
               if (exp_rd.size() == 0) fail("unexpected_read");
               else check("rd_addr", m_addr, exp_rd.pop_front());
            end else begin
               logic [63:0] e;
               wmem[m_addr] = m_wdata;
               wr_done++;
               if (exp_wr.size() == 0) fail("unexpected_write");
               else begin
                  e = exp_wr.pop_front();
                  check("wr_addr", m_addr, e[63:32]);
                  check("wr_data", m_wdata, e[31:0]);
               end
            end
         end
      end else begin
         if (pend) fail("req_dropped");
         pend    = 1'b0;
         m_wait  = 1'b0;
         m_rdata = $urandom;
      end
   end

   task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      s_addr = a; s_wdata = d; s_write = 1'b1;
      @(negedge clk);
      s_write = 1'b0;
   endtask

   task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      s_addr = a; s_read = 1'b1;
      @(negedge clk);
      s_read = 1'b0;
      d = s_rdata;
   endtask

   task automatic wait_idle(input int bound);
      logic [31:0] st;
      int k;
      k = 0;
      st = 32'h1;
      while (st[0] && k < bound) begin
         reg_rd(4'd1, st);
         k++;
      end
      if (st[0]) fail("idle_timeout");
   endtask

   task automatic fill(input logic [31:0] src, input int len);
      for (int i = 0; i < len; i++) begin
         case ($urandom_range(0, 5))
            0:       mem[src + 32'(4 * i)] = 32'h8000_8000;
            1:       mem[src + 32'(4 * i)] = 32'h7FFF_8000;
            default: mem[src + 32'(4 * i)] = $urandom;
         endcase
      end
   endtask

   task automatic run(input logic [31:0] src, input logic [31:0] dst, input int len,
                      input bit mode, input bit irq_en);
      for (int i = 0; i < len; i++) begin
         exp_rd.push_back(src + 32'(4 * i));
         exp_wr.push_back({dst + 32'(4 * i), mag_model(rmem(src + 32'(4 * i)), mode)});
      end
      reg_wr(4'd2, src);
      reg_wr(4'd3, dst);
      reg_wr(4'd4, 32'(len));
      reg_wr(4'd0, {29'b0, irq_en, mode, 1'b1});
   endtask

   task automatic finish_check(input string tag, input int len, input bit irq_en);
      logic [31:0] d;
      wait_idle(3000);
      reg_rd(4'd5, d);
      check({tag, "_count"}, d, 32'(len));
      reg_rd(4'd1, d);
      check({tag, "_status"}, d, 32'h2);
      check({tag, "_irq"}, {31'b0, irq}, {31'b0, irq_en});
      check({tag, "_drained"}, 32'(exp_wr.size() + exp_rd.size()), 32'h0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] src;
      logic [31:0] dst;
      int len, base, n, k;
      bit mode, ie;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset state
      check("rst_bus", {29'b0, m_read, m_write, irq}, 32'h0);
      check("rst_addr", m_addr, 32'h0);
      for (int a = 0; a < 8; a++) begin
         reg_rd(4'(a), d);
         check("rst_reg", d, 32'h0);
      end

      // the model itself, against hand-computed values
      check("model_3_4", mag_model(32'h0003_0004, 1'b0), 32'd25);
      check("model_m5_12", mag_model(32'hFFFB_000C, 1'b0), 32'd169);
      check("model_abs", mag_model(32'hFFFB_000C, 1'b1), 32'd17);
      check("model_abs_min", mag_model(32'h8000_8000, 1'b1), 32'h0001_0000);
      check("model_sq_min", mag_model(32'h8000_8000, 1'b0), 32'h8000_0000);

      // basic two-sample run
      mem[32'h100] = 32'h0003_0004;
      mem[32'h104] = 32'hFFFB_000C;
      run(32'h100, 32'h200, 2, 1'b0, 1'b0);
      finish_check("t1", 2, 1'b0);
      check("t1_w0", rwmem(32'h200), 32'd25);
      check("t1_w1", rwmem(32'h204), 32'd169);

      // most-negative components in both modes
      mem[32'h300] = 32'h8000_8000;
      run(32'h300, 32'h400, 1, 1'b1, 1'b0);
      finish_check("t2a", 1, 1'b0);
      check("t2_abs", rwmem(32'h400), 32'h0001_0000);
      run(32'h300, 32'h404, 1, 1'b0, 1'b0);
      finish_check("t2b", 1, 1'b0);
      check("t2_sq", rwmem(32'h404), 32'h8000_0000);

      // five-cycle stall on every request
      fixed_stall = 1'b1;
      fixed_len = 5;
      fill(32'h1000, 3);
      run(32'h1000, 32'h2000, 3, 1'b0, 1'b1);
      finish_check("t3", 3, 1'b1);
      reg_wr(4'd1, 32'h2);
      fixed_stall = 1'b0;

      // random runs, first one wrapping the address space
      for (int r = 0; r < 6; r++) begin
         src  = (r == 0) ? 32'hFFFF_FFF8 : {20'h0, 8'($urandom_range(0, 255)), 4'h0} + 32'h1_0000;
         dst  = (r == 0) ? 32'hFFFF_FFFC : {20'h0, 8'($urandom_range(0, 255)), 4'h0} + 32'h2_0000;
         len  = (r == 0) ? 4 : $urandom_range(1, 8);
         mode = 1'($urandom_range(0, 1));
         ie   = 1'($urandom_range(0, 1));
         fill(src, len);
         run(src, dst, len, mode, ie);
         finish_check("rand", len, ie);
         reg_wr(4'd1, 32'h2);
         check("rand_irq_clr", {31'b0, irq}, 32'h0);
      end

      // zero length: done and irq without bus traffic
      reg_wr(4'd4, 32'h0);
      reg_wr(4'd0, 32'h5);
      k = 0;
      while (!irq && k < 5) begin
         @(negedge clk);
         k++;
      end
      check("len0_irq", {31'b0, irq}, 32'h1);
      reg_rd(4'd1, d);
      check("len0_status", d, 32'h2);
      reg_rd(4'd5, d);
      check("len0_count", d, 32'h0);
      reg_wr(4'd1, 32'h2);
      check("len0_irq_clr", {31'b0, irq}, 32'h0);

      // abort a long run; START and SRC writes while busy are ignored
      fill(32'h4000, 100);
      base = wr_done;
      run(32'h4000, 32'h8000, 100, 1'b0, 1'b0);
      k = 0;
      while ((wr_done - base) < 3 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      reg_wr(4'd0, 32'h1);
      reg_wr(4'd2, 32'hDEAD_0000);
      k = 0;
      while ((wr_done - base) < 10 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      reg_wr(4'd0, 32'h8);
      wait_idle(500);
      n = wr_done - base;
      reg_rd(4'd5, d);
      check("abort_count", d, 32'(n));
      check("abort_count_range", {31'b0, (n == 10 || n == 11)}, 32'h1);
      reg_rd(4'd1, d);
      check("abort_status", d, 32'h4);
      reg_rd(4'd2, d);
      check("abort_src_kept", d, 32'h4000);
      exp_rd.delete();
      exp_wr.delete();
      repeat (20) @(negedge clk);

      // asynchronous reset during a stalled write
      fixed_stall = 1'b1;
      fixed_len = 3;
      fill(32'h500, 4);
      run(32'h500, 32'h600, 4, 1'b1, 1'b0);
      k = 0;
      while (!m_write && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("t6_saw_write", {31'b0, m_write}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_bus_drop", {30'b0, m_read, m_write}, 32'h0);
      check("t6_addr", m_addr, 32'h0);
      check("t6_wdata", m_wdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_rd.delete();
      exp_wr.delete();
      fixed_stall = 1'b0;
      for (int a = 0; a < 6; a++) begin
         reg_rd(4'(a), d);
         check("t6_reg", d, 32'h0);
      end
      check("t6_irq", {31'b0, irq}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
